// File: rtl/bsg_manycore_cache_req_arbiter_pkg.sv
// Shared helpers for the manycore cache request arbiter slice.
package bsg_manycore_cache_req_arbiter_pkg;

  // Never returns zero, so a one-entry or one-requester configuration still gets a 1-bit field.
  function automatic int safe_clog2(input int x);
    if (x <= 1) begin
      return 1;
    end else begin
      return $clog2(x);
    end
  endfunction

endpackage

// File: rtl/bsg_fifo_1r1w_small.sv
// Small one-read one-write FIFO with a valid/ready input and a valid/yumi output.
module bsg_fifo_1r1w_small
  import bsg_manycore_cache_req_arbiter_pkg::*;
#(
  parameter int width_p = 1,
  parameter int els_p = 2,
  localparam int lg_els_lp = safe_clog2(els_p),
  localparam int lg_cnt_lp = safe_clog2(els_p + 1)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  output logic               ready_o,
  input  logic [width_p-1:0] data_i,
  output logic               v_o,
  output logic [width_p-1:0] data_o,
  input  logic               yumi_i
);

  logic [width_p-1:0]   mem_r [els_p];
  logic [lg_els_lp-1:0] wptr_r;
  logic [lg_els_lp-1:0] rptr_r;
  logic [lg_cnt_lp-1:0] count_r;
  logic                 push_s;
  logic                 pop_s;

  // Ready only reflects registered occupancy, so a same-cycle pop never frees a slot.
  assign ready_o = (count_r != lg_cnt_lp'(els_p));
  assign v_o     = (count_r != lg_cnt_lp'(0));
  assign data_o  = mem_r[rptr_r];
  assign push_s  = v_i & ready_o;
  assign pop_s   = yumi_i & v_o;

  // Storage array, written on push.
  always_ff @(posedge clk_i) begin
    if (push_s) begin
      mem_r[wptr_r] <= data_i;
    end
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
    end else begin
      if (push_s) begin
        wptr_r <= (wptr_r == lg_els_lp'(els_p - 1)) ? '0 : wptr_r + lg_els_lp'(1);
      end
      if (pop_s) begin
        rptr_r <= (rptr_r == lg_els_lp'(els_p - 1)) ? '0 : rptr_r + lg_els_lp'(1);
      end
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + lg_cnt_lp'(1);
        2'b01:   count_r <= count_r - lg_cnt_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/bsg_manycore_cache_req_arbiter_checker.sv
// Protocol checks for bsg_manycore_cache_req_arbiter, meant to be bound onto the top.
module bsg_manycore_cache_req_arbiter_checker #(
  parameter int num_req_p = 2,
  parameter int cache_pkt_width_p = 8,
  parameter int lg_out_lp = 3
) (
  input logic                         clk_i,
  input logic                         reset_n_i,
  input logic                         v_o,
  input logic                         ready_i,
  input logic [cache_pkt_width_p-1:0] cache_pkt_o,
  input logic                         v_i,
  input logic [lg_out_lp-1:0]         outstanding_o,
  input logic [num_req_p-1:0]         req_v_o,
  input logic [num_req_p-1:0]         req_yumi_i
);

  logic                         stall_r;
  logic [cache_pkt_width_p-1:0] pkt_r;

  // Remember a stalled offer so the next cycle can be compared against it.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      stall_r <= 1'b0;
      pkt_r   <= '0;
    end else begin
      stall_r <= v_o & ~ready_i;
      pkt_r   <= cache_pkt_o;
    end
  end

  // Requester hold rule, responses only when something is outstanding, no stray yumi.
  always_ff @(posedge clk_i) begin
    if (reset_n_i) begin
      assert (!(stall_r && (!v_o || (cache_pkt_o != pkt_r))))
        else $error("stalled packet withdrawn or changed");
      assert (!(v_i && (outstanding_o == '0)))
        else $error("cache response with no outstanding request");
      assert ((req_yumi_i & ~req_v_o) == '0)
        else $error("requester yumi without response valid");
    end
  end

endmodule

// File: rtl/bsg_manycore_cache_req_arbiter.sv
// Round-robin shares one bsg_cache between several link adapters and routes
// in-order cache responses back to the requester that issued each packet.
module bsg_manycore_cache_req_arbiter
  import bsg_manycore_cache_req_arbiter_pkg::*;
#(
  parameter int num_req_p = 2,
  parameter int cache_pkt_width_p = 8,
  parameter int data_width_p = 32,
  parameter int max_out_p = 4,
  localparam int lg_num_req_lp = safe_clog2(num_req_p),
  localparam int lg_out_lp = safe_clog2(max_out_p + 1)
) (
  input  logic                                   clk_i,
  input  logic                                   reset_n_i,
  input  logic [num_req_p*cache_pkt_width_p-1:0] req_pkt_i,
  input  logic [num_req_p-1:0]                   req_v_i,
  output logic [num_req_p-1:0]                   req_ready_o,
  output logic [cache_pkt_width_p-1:0]           cache_pkt_o,
  output logic                                   v_o,
  input  logic                                   ready_i,
  input  logic [data_width_p-1:0]                data_i,
  input  logic                                   v_i,
  output logic                                   yumi_o,
  output logic [num_req_p*data_width_p-1:0]      req_data_o,
  output logic [num_req_p-1:0]                   req_v_o,
  input  logic [num_req_p-1:0]                   req_yumi_i,
  output logic [lg_out_lp-1:0]                   outstanding_o
);

  logic [lg_num_req_lp-1:0] rr_r;
  logic                     lock_v_r;
  logic [lg_num_req_lp-1:0] lock_id_r;
  logic [lg_out_lp-1:0]     count_r;

  logic [lg_num_req_lp-1:0] grant_s;
  logic [lg_num_req_lp-1:0] idx_s;
  logic [lg_num_req_lp:0]   sum_s;
  logic                     found_s;
  logic                     offer_s;
  logic                     full_s;
  logic                     accept_s;
  logic                     fifo_ready_s;
  logic                     fifo_v_s;
  logic [lg_num_req_lp-1:0] head_s;
  logic                     rsp_v_s;
  logic                     head_yumi_s;

  // Grant: a stalled offer stays locked, otherwise first valid at or after the rr pointer.
  always_comb begin
    grant_s = rr_r;
    found_s = 1'b0;
    idx_s   = rr_r;
    sum_s   = '0;
    if (lock_v_r) begin
      grant_s = lock_id_r;
    end else begin
      for (int k = 0; k < num_req_p; k++) begin
        sum_s   = {1'b0, rr_r} + (lg_num_req_lp + 1)'(k);
        idx_s   = (sum_s >= (lg_num_req_lp + 1)'(num_req_p))
                  ? lg_num_req_lp'(sum_s - (lg_num_req_lp + 1)'(num_req_p))
                  : lg_num_req_lp'(sum_s);
        grant_s = (!found_s && req_v_i[idx_s]) ? idx_s : grant_s;
        found_s = found_s | req_v_i[idx_s];
      end
    end
  end

  assign full_s     = ~fifo_ready_s;
  assign offer_s    = lock_v_r ? req_v_i[lock_id_r] : (|req_v_i);
  assign v_o        = offer_s & ~full_s & reset_n_i;
  assign accept_s   = v_o & ready_i;
  assign rsp_v_s    = v_i & fifo_v_s & reset_n_i;
  assign yumi_o     = rsp_v_s & head_yumi_s;
  assign req_data_o = {num_req_p{data_i}};
  assign outstanding_o = reset_n_i ? count_r : '0;

  // Packet mux, per-requester ready and response steering by FIFO head id.
  always_comb begin
    cache_pkt_o = '0;
    req_ready_o = '0;
    req_v_o     = '0;
    head_yumi_s = 1'b0;
    for (int i = 0; i < num_req_p; i++) begin
      if (grant_s == lg_num_req_lp'(i)) begin
        cache_pkt_o    = req_pkt_i[i*cache_pkt_width_p +: cache_pkt_width_p];
        req_ready_o[i] = ready_i & ~full_s & reset_n_i;
      end else begin
        req_ready_o[i] = 1'b0;
      end
      req_v_o[i]  = rsp_v_s & (head_s == lg_num_req_lp'(i));
      head_yumi_s = head_yumi_s | (req_yumi_i[i] & (head_s == lg_num_req_lp'(i)));
    end
  end

  // Round-robin pointer, stall lock and outstanding count.
  always_ff @(posedge clk_i) begin
    if (!reset_n_i) begin
      rr_r      <= '0;
      lock_v_r  <= 1'b0;
      lock_id_r <= '0;
      count_r   <= '0;
    end else begin
      if (accept_s) begin
        rr_r     <= (grant_s == lg_num_req_lp'(num_req_p - 1)) ? '0 : grant_s + lg_num_req_lp'(1);
        lock_v_r <= 1'b0;
      end else if (v_o && !ready_i) begin
        lock_v_r  <= 1'b1;
        lock_id_r <= grant_s;
      end
      case ({accept_s, yumi_o})
        2'b10:   count_r <= count_r + lg_out_lp'(1);
        2'b01:   count_r <= count_r - lg_out_lp'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  bsg_fifo_1r1w_small #(
    .width_p(lg_num_req_lp),
    .els_p  (max_out_p)
  ) order_fifo (
    .clk_i  (clk_i),
    .reset_i(~reset_n_i),
    .v_i    (accept_s),
    .ready_o(fifo_ready_s),
    .data_i (grant_s),
    .v_o    (fifo_v_s),
    .data_o (head_s),
    .yumi_i (yumi_o)
  );

endmodule

// File: doc/bsg_manycore_cache_req_arbiter.md
Name: bsg_manycore_cache_req_arbiter

Overview:
Shares one bsg_cache instance between num_req_p manycore-link-to-cache front-ends. Round-robin arbitrates cache packets into the cache, then steers in-order cache responses back to the requester that issued each one. Sits between the per-link cache adapters and the cache in each vcache tile. Bounds outstanding requests with an order-tracking FIFO.

Parameters:
num_req_p, 2, number of requesters (>=2)
cache_pkt_width_p, required, width of one bsg_cache packet
data_width_p, 32, cache response data width
max_out_p, 4, max outstanding accepted-but-unreturned requests (order FIFO depth)
lg_num_req_lp, localparam, `BSG_SAFE_CLOG2(num_req_p)
lg_out_lp, localparam, `BSG_SAFE_CLOG2(max_out_p+1)

Ports:
clk_i  in  1  clock
reset_n_i  in  1  synchronous reset, active-low
req_pkt_i  in  num_req_p*cache_pkt_width_p  packet per requester; slot i = bits [i*W+:W]
req_v_i  in  num_req_p  requester packet valid
req_ready_o  out  num_req_p  packet accepted when req_v_i[i] & req_ready_o[i]
cache_pkt_o  out  cache_pkt_width_p  packet to cache
v_o  out  1  packet valid to cache
ready_i  in  1  cache ready
data_i  in  data_width_p  cache response data
v_i  in  1  cache response valid
yumi_o  out  1  response consumed
req_data_o  out  num_req_p*data_width_p  response data, broadcast to all slots
req_v_o  out  num_req_p  response valid, one-hot at FIFO head id
req_yumi_i  in  num_req_p  requester consumes response
outstanding_o  out  lg_out_lp  current order-FIFO occupancy

Behaviour:
- Reset (reset_n_i=0 at clk edge): rr pointer=0, lock_v_r=0, order FIFO empty. Outputs while reset_n_i=0: v_o=0, req_ready_o=0, yumi_o=0, req_v_o=0, outstanding_o=0.
- Full condition: full = (count==max_out_p). Push is blocked when full, even if a pop occurs in the same cycle.
- Grant:
  - If lock_v_r=1, grant=lock_id_r.
  - Otherwise grant = first i with req_v_i[i]=1, searching from rr pointer upward mod num_req_p.
- v_o = |req_v_i & ~full (with lock, req_v_i[lock_id_r]). cache_pkt_o = req_pkt_i slot grant.
- Stall lock: if v_o & ~ready_i, set lock_v_r=1, lock_id_r=grant; cleared on accept. Requesters must hold valid and packet stable once offered (assert in sim).
- req_ready_o[i] = (i==grant) & ready_i & ~full & reset_n_i.
- Accept (v_o & ready_i):
  - push grant id into order FIFO
  - rr pointer <= (grant+1) mod num_req_p
  - packet passes combinationally, zero cycles of arbiter latency
- Response path: the cache returns responses in acceptance order.
  - head = FIFO head id
  - req_v_o[head] = v_i & ~empty; req_data_o = data_i
  - yumi_o = v_i & ~empty & req_yumi_i[head]; pop on yumi_o
- Simultaneous push and pop when not full: count unchanged, both take effect.
- v_i while empty: illegal. yumi_o=0, req_v_o=0, sim $error.
- req_yumi_i[i] without req_v_o[i]: ignored, sim $error.
- TAGST traffic issued by an adapter in its CLEAR_TAG state is arbitrated like any other packet; no special casing.
- Mid-operation reset: all in-flight tracking is discarded. The cache must be reset in the same cycle.

Decomposition:
- No new package typedefs. Packet width derives from `bsg_cache_pkt_width in bsg_cache_pkg at instantiation.
- Order FIFO: instantiate existing bsg_fifo_1r1w_small (els=max_out_p, width=lg_num_req_lp), with active-high reset = ~reset_n_i.
- Write the arbitration and lock inline; no new sub-module is needed.

Test Plan:
- Both requesters hold valid, ready_i=1, 4 packets each -> grants alternate 0,1,0,1,...; FIFO ids match; responses return to the correct slot.
- Req0 valid, ready_i=0 for 3 cycles, req1 raises valid in cycle 2 -> grant stays 0 (locked); accept on ready_i=1; next grant=1.
- max_out_p=4, no responses, 6 requests -> 4 accepted, outstanding_o=4, v_o=0, req_ready_o=0 until a pop; a pop and a new request in the same cycle -> push still blocked that cycle.
- Response for req1 at head with req_yumi_i[1]=0 for 2 cycles -> yumi_o=0, data held; req_yumi_i[1]=1 -> pop, outstanding_o decrements by 1.
- reset_n_i low for one cycle with 3 outstanding -> outstanding_o=0, rr pointer=0, next grant goes to requester 0.
- v_i=1 while FIFO empty -> yumi_o=0, req_v_o=0, $error raised.
